// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Result-bus arbiter between the execution units and reg_stat. Each of NSRC
//   sources owns a small FIFO of completed results {tag, addr, data}. Every
//   cycle up to three FIFO heads are granted round-robin and driven out on the
//   registered write ports 0..2, with the matching tag broadcast on cdb_tag*.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   rdy                 global enable; low freezes all state and outputs
//   flush               drops every buffered result, clears outputs and rr_ptr
//   src_valid/src_ready per-source handshake; src_tag/addr/data are slice i
//   en_w0..2            write port k valid (one cycle per grant)
//   reg_write_addr0..2  write port k destination register
//   write_data0..2      write port k data
//   cdb_tag0..2         tag retired on port k
//
// Handshake: a result on source i transfers at a rising edge where
//   src_valid[i] && src_ready[i] && !flush. src_ready[i] depends only on the
//   registered FIFO count (plus rst/rdy), never on same-cycle pops, so a full
//   FIFO that is granted this cycle reopens on the following cycle.
module cdb_arbiter #(
  parameter int NSRC   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC*TAG_W-1:0]   src_tag,
  input  logic [NSRC*ADDR_W-1:0]  src_addr,
  input  logic [NSRC*DATA_W-1:0]  src_data,
  output logic                    en_w0,
  output logic                    en_w1,
  output logic                    en_w2,
  output logic [ADDR_W-1:0]       reg_write_addr0,
  output logic [ADDR_W-1:0]       reg_write_addr1,
  output logic [ADDR_W-1:0]       reg_write_addr2,
  output logic [DATA_W-1:0]       write_data0,
  output logic [DATA_W-1:0]       write_data1,
  output logic [DATA_W-1:0]       write_data2,
  output logic [TAG_W-1:0]        cdb_tag0,
  output logic [TAG_W-1:0]        cdb_tag1,
  output logic [TAG_W-1:0]        cdb_tag2
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int RW    = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int NPORT = 3;

  // FIFO storage and bookkeeping
  logic [TAG_W-1:0]  mem_tag  [NSRC][DEPTH];
  logic [ADDR_W-1:0] mem_addr [NSRC][DEPTH];
  logic [DATA_W-1:0] mem_data [NSRC][DEPTH];
  logic [PW-1:0]     wr_ptr   [NSRC];
  logic [PW-1:0]     rd_ptr   [NSRC];
  logic [CW-1:0]     count    [NSRC];
  logic [RW-1:0]     rr_ptr;

  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   grant;

  // Next-cycle port contents from arbitration
  logic              port_en_n   [NPORT];
  logic [TAG_W-1:0]  port_tag_n  [NPORT];
  logic [ADDR_W-1:0] port_addr_n [NPORT];
  logic [DATA_W-1:0] port_data_n [NPORT];
  logic [RW-1:0]     rr_next;

  // Registered ports
  logic              out_en   [NPORT];
  logic [TAG_W-1:0]  out_tag  [NPORT];
  logic [ADDR_W-1:0] out_addr [NPORT];
  logic [DATA_W-1:0] out_data [NPORT];

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = rst && rdy && (count[i] < CW'(DEPTH));
      push[i]      = src_valid[i] && src_ready[i] && !flush;
    end
  end

  // Round-robin scan starting at rr_ptr. A head whose non-zero addr matches
  // an earlier grant this cycle is skipped so two writes never hit the same
  // register in one cycle; addr 0 is exempt because reg_stat drops it anyway.
  always_comb begin
    int n;
    int idx;
    logic conflict;
    logic [ADDR_W-1:0] head_addr;
    n         = 0;
    idx       = 0;
    conflict  = 1'b0;
    head_addr = '0;
    grant     = '0;
    rr_next   = rr_ptr;
    for (int p = 0; p < NPORT; p++) begin
      port_en_n[p]   = 1'b0;
      port_tag_n[p]  = '0;
      port_addr_n[p] = '0;
      port_data_n[p] = '0;
    end
    for (int k = 0; k < NSRC; k++) begin
      idx       = (int'(rr_ptr) + k) % NSRC;
      head_addr = mem_addr[idx][rd_ptr[idx]];
      conflict  = 1'b0;
      for (int j = 0; j < NPORT; j++) begin
        if (j < n && head_addr != '0 && port_addr_n[j] == head_addr)
          conflict = 1'b1;
      end
      if (n < NPORT && count[idx] != '0 && !conflict) begin
        grant[idx]     = 1'b1;
        port_en_n[n]   = 1'b1;
        port_tag_n[n]  = mem_tag[idx][rd_ptr[idx]];
        port_addr_n[n] = head_addr;
        port_data_n[n] = mem_data[idx][rd_ptr[idx]];
        rr_next        = RW'((idx + 1) % NSRC);
        n              = n + 1;
      end
    end
  end

  // Storage writes carry no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        mem_tag[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
        mem_addr[i][wr_ptr[i]] <= src_addr[i*ADDR_W +: ADDR_W];
        mem_data[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
      for (int p = 0; p < NPORT; p++) begin
        out_en[p]   <= 1'b0;
        out_tag[p]  <= '0;
        out_addr[p] <= '0;
        out_data[p] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      rr_ptr <= rr_next;
      for (int p = 0; p < NPORT; p++) begin
        out_en[p]   <= port_en_n[p];
        out_tag[p]  <= port_tag_n[p];
        out_addr[p] <= port_addr_n[p];
        out_data[p] <= port_data_n[p];
      end
    end
  end

  assign en_w0           = out_en[0];
  assign en_w1           = out_en[1];
  assign en_w2           = out_en[2];
  assign reg_write_addr0 = out_addr[0];
  assign reg_write_addr1 = out_addr[1];
  assign reg_write_addr2 = out_addr[2];
  assign write_data0     = out_data[0];
  assign write_data1     = out_data[1];
  assign write_data2     = out_data[2];
  assign cdb_tag0        = out_tag[0];
  assign cdb_tag1        = out_tag[1];
  assign cdb_tag2        = out_tag[2];

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NSRC   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAG_W  = 4;
  localparam int W      = 2 + TAG_W + ADDR_W + DATA_W;

  logic                   clk;
  logic                   rst;
  logic                   rdy;
  logic                   flush;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC*TAG_W-1:0]  src_tag;
  logic [NSRC*ADDR_W-1:0] src_addr;
  logic [NSRC*DATA_W-1:0] src_data;
  logic                   en_w0, en_w1, en_w2;
  logic [ADDR_W-1:0]      reg_write_addr0, reg_write_addr1, reg_write_addr2;
  logic [DATA_W-1:0]      write_data0, write_data1, write_data2;
  logic [TAG_W-1:0]       cdb_tag0, cdb_tag1, cdb_tag2;

  cdb_arbiter #(.NSRC(NSRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_addr(src_addr), .src_data(src_data),
    .en_w0(en_w0), .en_w1(en_w1), .en_w2(en_w2),
    .reg_write_addr0(reg_write_addr0), .reg_write_addr1(reg_write_addr1),
    .reg_write_addr2(reg_write_addr2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .cdb_tag0(cdb_tag0), .cdb_tag1(cdb_tag1), .cdb_tag2(cdb_tag2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src_q0[$], src_q1[$], src_q2[$], src_q3[$];
  bit per_src_mode = 1'b0;
  bit edge_live    = 1'b0;

  function automatic logic [W-1:0] rec(input int p, input logic [TAG_W-1:0] t,
                                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [1:0] pp;
    pp = p[1:0];
    return {pp, t, a, d};
  endfunction

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function void push_src(input int s, input logic [W-1:0] v);
    case (s)
      0: src_q0.push_back(v);
      1: src_q1.push_back(v);
      2: src_q2.push_back(v);
      default: src_q3.push_back(v);
    endcase
  endfunction

  function automatic bit pop_src(input int s, output logic [W-1:0] v);
    v = '0;
    case (s)
      0: if (src_q0.size() != 0) begin v = src_q0.pop_front(); return 1'b1; end
      1: if (src_q1.size() != 0) begin v = src_q1.pop_front(); return 1'b1; end
      2: if (src_q2.size() != 0) begin v = src_q2.pop_front(); return 1'b1; end
      3: if (src_q3.size() != 0) begin v = src_q3.pop_front(); return 1'b1; end
      default: ;
    endcase
    return 1'b0;
  endfunction

  function int pending();
    return exp_q.size() + src_q0.size() + src_q1.size() + src_q2.size() + src_q3.size();
  endfunction

  // ---------------- monitor ----------------
  logic              mon_en   [3];
  logic [TAG_W-1:0]  mon_tag  [3];
  logic [ADDR_W-1:0] mon_addr [3];
  logic [DATA_W-1:0] mon_data [3];
  assign mon_en[0] = en_w0;  assign mon_en[1] = en_w1;  assign mon_en[2] = en_w2;
  assign mon_tag[0] = cdb_tag0; assign mon_tag[1] = cdb_tag1; assign mon_tag[2] = cdb_tag2;
  assign mon_addr[0] = reg_write_addr0; assign mon_addr[1] = reg_write_addr1;
  assign mon_addr[2] = reg_write_addr2;
  assign mon_data[0] = write_data0; assign mon_data[1] = write_data1; assign mon_data[2] = write_data2;

  // Outputs only carry new content after an edge where the DUT was enabled.
  always @(posedge clk) edge_live <= rst && (rdy || flush);

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (edge_live) begin
      for (int k = 0; k < 3; k++) begin
        if (mon_en[k]) begin
          if (per_src_mode) begin
            if (pop_src(int'(mon_data[k][31:28]), e))
              check("src_order", 64'(rec(0, mon_tag[k], mon_addr[k], mon_data[k])), 64'(e));
            else
              check("unexpected_src_output", 64'(mon_data[k]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(rec(k, mon_tag[k], mon_addr[k], mon_data[k])),
                  64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("port_result", 64'(rec(k, mon_tag[k], mon_addr[k], mon_data[k])), 64'(e));
          end
        end else begin
          check("idle_port_zero", 64'({mon_tag[k], mon_addr[k], mon_data[k]}), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    src_valid[i]               = v;
    src_tag[i*TAG_W +: TAG_W]   = t;
    src_addr[i*ADDR_W +: ADDR_W] = a;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_tag   = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (pending() == 0) break;
      step();
    end
    check("drain_timeout", 64'(pending()), 64'd0);
    step();
  endtask

  // ---------------- stimulus ----------------
  int  seq [NSRC];
  bit  saw_full0;

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    clear_src();
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, 4'hF, 5'd31, 32'hFFFF_0000 + i);

    // Reset held three cycles with every source offering
    repeat (3) begin
      step();
      check("rst_en", 64'({en_w0, en_w1, en_w2}), 64'd0);
      check("rst_ready", 64'(src_ready), 64'd0);
      check("rst_outs", 64'({reg_write_addr0, write_data0, cdb_tag0}), 64'd0);
    end
    rst = 1'b1;
    clear_src();
    #1;
    check("ready_after_rst", 64'(src_ready), 64'hF);
    repeat (3) step();
    check("nothing_accepted_in_rst", 64'({en_w0, en_w1, en_w2}), 64'd0);

    // Single result from source 2
    set_src(2, 1'b1, 4'd5, 5'd7, 32'hDEAD_BEEF);
    exp_q.push_back(rec(0, 4'd5, 5'd7, 32'hDEAD_BEEF));
    step();
    clear_src();
    check("single_not_yet", 64'(en_w0), 64'd0);
    step();
    check("single_en", 64'({en_w0, en_w1, en_w2}), 64'b100);
    check("single_addr", 64'(reg_write_addr0), 64'd7);
    check("single_data", 64'(write_data0), 64'hDEAD_BEEF);
    step();
    check("single_once", 64'(en_w0), 64'd0);
    drain(5);

    // Flush brings rr_ptr back to 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clear", 64'({en_w0, en_w1, en_w2}), 64'd0);

    // Four simultaneous results, addrs 1..4
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, TAG_W'(8 + i), ADDR_W'(i + 1), 32'h100 + i);
    exp_q.push_back(rec(0, 4'd8,  5'd1, 32'h100));
    exp_q.push_back(rec(1, 4'd9,  5'd2, 32'h101));
    exp_q.push_back(rec(2, 4'd10, 5'd3, 32'h102));
    exp_q.push_back(rec(0, 4'd11, 5'd4, 32'h103));
    step();
    clear_src();
    step();
    check("four_cycle1_en", 64'({en_w0, en_w1, en_w2}), 64'b111);
    check("four_cycle1_tag2", 64'(cdb_tag2), 64'd10);
    step();
    check("four_cycle2_en", 64'({en_w0, en_w1, en_w2}), 64'b100);
    check("four_cycle2_tag0", 64'(cdb_tag0), 64'd11);
    drain(5);

    // Address conflict on addr 9 (rr_ptr = 0)
    set_src(0, 1'b1, 4'd1, 5'd9, 32'hA1);
    set_src(1, 1'b1, 4'd2, 5'd9, 32'hA2);
    exp_q.push_back(rec(0, 4'd1, 5'd9, 32'hA1));
    exp_q.push_back(rec(0, 4'd2, 5'd9, 32'hA2));
    step();
    clear_src();
    step();
    check("conflict_c1_en", 64'({en_w0, en_w1, en_w2}), 64'b100);
    check("conflict_c1_tag", 64'(cdb_tag0), 64'd1);
    step();
    check("conflict_c2_en", 64'({en_w0, en_w1, en_w2}), 64'b100);
    check("conflict_c2_tag", 64'(cdb_tag0), 64'd2);
    drain(5);

    // Two addr-0 results are granted together (rr_ptr = 2)
    set_src(2, 1'b1, 4'd3, 5'd0, 32'hB2);
    set_src(3, 1'b1, 4'd4, 5'd0, 32'hB3);
    exp_q.push_back(rec(0, 4'd3, 5'd0, 32'hB2));
    exp_q.push_back(rec(1, 4'd4, 5'd0, 32'hB3));
    step();
    clear_src();
    step();
    check("addr0_both_en", 64'({en_w0, en_w1, en_w2}), 64'b110);
    drain(5);

    // Backpressure: all four sources offer every cycle
    per_src_mode = 1'b1;
    saw_full0    = 1'b0;
    for (int i = 0; i < NSRC; i++) seq[i] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NSRC; i++)
        set_src(i, 1'b1, {2'(i), 2'(seq[i])}, ADDR_W'(10 + i),
                {4'(i), 12'h0, 16'(seq[i])});
      @(negedge clk);
      for (int i = 0; i < NSRC; i++) begin
        if (src_ready[i]) begin
          push_src(i, rec(0, {2'(i), 2'(seq[i])}, ADDR_W'(10 + i), {4'(i), 12'h0, 16'(seq[i])}));
          seq[i]++;
        end
      end
      if (!src_ready[0]) saw_full0 = 1'b1;
      @(posedge clk);
      #1;
    end
    clear_src();
    check("src0_backpressured", 64'(saw_full0), 64'd1);
    check("src0_progress", 64'(seq[0] > 10), 64'd1);
    drain(30);
    per_src_mode = 1'b0;

    // rdy low freezes outputs, then flush drops buffered entries
    set_src(2, 1'b1, 4'd6, 5'd12, 32'hC2);
    exp_q.push_back(rec(0, 4'd6, 5'd12, 32'hC2));
    step();
    clear_src();
    set_src(0, 1'b1, 4'd7, 5'd13, 32'hC0);
    set_src(1, 1'b1, 4'd8, 5'd14, 32'hC1);
    step();
    clear_src();
    rdy = 1'b0;
    #1;
    check("rdy_low_ready", 64'(src_ready), 64'd0);
    repeat (4) begin
      step();
      check("frozen_en", 64'({en_w0, en_w1, en_w2}), 64'b100);
      check("frozen_data", 64'(write_data0), 64'hC2);
      check("frozen_tag", 64'(cdb_tag0), 64'd6);
      check("frozen_ready", 64'(src_ready), 64'd0);
    end
    rdy   = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("post_flush_en", 64'({en_w0, en_w1, en_w2}), 64'd0);
    check("post_flush_outs", 64'({reg_write_addr0, write_data0, cdb_tag0}), 64'd0);
    check("post_flush_ready", 64'(src_ready), 64'hF);
    repeat (6) step();
    check("no_stale_entries", 64'({en_w0, en_w1, en_w2}), 64'd0);
    check("queue_empty_end", 64'(pending()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
